// File: rtl/branch_exec_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// branch_exec_unit
// Multi-cycle branch execution unit for the LEGv8 datapath. The main control
// unit pulses start with a branch instruction, waits for done, then writes
// pc_out into the PC. Handles B, BL, BR, CBZ, CBNZ and B.cond. The FSM runs
// IDLE -> EX0 -> EX1 -> IDLE, so done arrives two cycles after start.
//
// Optional feature macro: BRANCH_STATS_EN (taken / not-taken statistics
// counters). When it is undefined, taken_cnt and nt_cnt are tied to zero.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high
//   start      in   begin a branch; sampled only in IDLE
//   IR         in   instruction word, latched with start
//   pc         in   PC of the branch instruction, latched with start
//   reg_val    in   register file data for rd_addr, sampled at end of EX0
//   flags_in   in   {V,C,N,Z} from the ALU
//   flags_we   in   load flags_in into the flag register (any state)
//   rd_addr    out  register to read (Rt for CBZ/CBNZ, Rn for BR, else 0)
//   busy       out  high in EX0 and EX1
//   done       out  one-cycle pulse in EX1
//   pc_load    out  same as done
//   pc_out     out  next PC
//   link_we    out  one-cycle pulse in EX0 for BL
//   link_addr  out  constant X30
//   link_val   out  latched pc + 4
//   illegal    out  with done: IR was not a supported branch
//   taken_cnt  out  taken branch count (BRANCH_STATS_EN only)
//   nt_cnt     out  not-taken conditional branch count (BRANCH_STATS_EN only)
// -----------------------------------------------------------------------------
module branch_exec_unit #(
  parameter int PC_W   = 64,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       IR,
  input  logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] reg_val,
  input  logic [3:0]        flags_in,
  input  logic              flags_we,
  output logic [4:0]        rd_addr,
  output logic              busy,
  output logic              done,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_out,
  output logic              link_we,
  output logic [4:0]        link_addr,
  output logic [PC_W-1:0]   link_val,
  output logic              illegal,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  nt_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_EX0, S_EX1} state_t;
  typedef enum logic [2:0] {K_B, K_BL, K_BR, K_CBZ, K_CBNZ, K_BCOND, K_ILL} kind_t;

  function automatic kind_t decode(input logic [31:0] ir);
    if (ir[31:26] == 6'b000101)            return K_B;
    else if (ir[31:26] == 6'b100101)       return K_BL;
    else if (ir[31:24] == 8'b10110100)     return K_CBZ;
    else if (ir[31:24] == 8'b10110101)     return K_CBNZ;
    else if (ir[31:24] == 8'b01010100)     return K_BCOND;
    else if (ir[31:21] == 11'b11010110000) return K_BR;
    else                                   return K_ILL;
  endfunction

  // f = {V,C,N,Z}
  function automatic logic cond_hold(input logic [3:0] cond, input logic [3:0] f);
    logic v, c, n, z;
    {v, c, n, z} = f;
    case (cond)
      4'd0:    return z;
      4'd1:    return ~z;
      4'd2:    return c;
      4'd3:    return ~c;
      4'd4:    return n;
      4'd5:    return ~n;
      4'd6:    return v;
      4'd7:    return ~v;
      4'd8:    return c & ~z;
      4'd9:    return ~c | z;
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return ~z & (n == v);
      4'd13:   return z | (n != v);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] rd_select(input logic [31:0] ir);
    case (decode(ir))
      K_CBZ, K_CBNZ: return ir[4:0];
      K_BR:          return ir[9:5];
      default:       return 5'd0;
    endcase
  endfunction

  state_t          state;
  logic [31:0]     ir_q;
  logic [PC_W-1:0] pc_q;
  logic [3:0]      flags_q;

  kind_t           kind;
  logic            taken;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] off26;
  logic [PC_W-1:0] off19;
  logic [PC_W-1:0] br_target;

  assign link_addr = 5'd30;

  // BR target: truncate or zero-extend the register value to PC width.
  if (DATA_W >= PC_W) begin : g_br_trunc
    assign br_target = reg_val[PC_W-1:0];
  end else begin : g_br_zext
    assign br_target = {{(PC_W-DATA_W){1'b0}}, reg_val};
  end

  // Branch resolution works on the latched instruction; reg_val and the flag
  // register are consumed at the EX0 -> EX1 edge.
  always_comb begin
    kind   = decode(ir_q);
    seq_pc = pc_q + PC_W'(4);
    off26  = {{(PC_W-28){ir_q[25]}}, ir_q[25:0], 2'b00};
    off19  = {{(PC_W-21){ir_q[23]}}, ir_q[23:5], 2'b00};
    taken  = 1'b0;
    target = seq_pc;
    case (kind)
      K_B, K_BL: begin
        taken  = 1'b1;
        target = pc_q + off26;
      end
      K_BR: begin
        taken  = 1'b1;
        target = br_target;
      end
      K_CBZ: begin
        taken  = (reg_val == '0);
        target = pc_q + off19;
      end
      K_CBNZ: begin
        taken  = (reg_val != '0);
        target = pc_q + off19;
      end
      K_BCOND: begin
        taken  = cond_hold(ir_q[3:0], flags_q);
        target = pc_q + off19;
      end
      default: begin
        taken  = 1'b0;
        target = seq_pc;
      end
    endcase
  end

  // NOTE: every register here uses non-blocking assignment, so the EX0 cycle
  // reads flags_q as it stood before the edge; a flags_we in that same EX0
  // cycle lands together with the branch decision and is not seen by it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      ir_q     <= '0;
      pc_q     <= '0;
      flags_q  <= '0;
      rd_addr  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pc_load  <= 1'b0;
      pc_out   <= '0;
      link_we  <= 1'b0;
      link_val <= '0;
      illegal  <= 1'b0;
    end else begin
      if (flags_we) flags_q <= flags_in;
      done    <= 1'b0;
      pc_load <= 1'b0;
      link_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ir_q     <= IR;
            pc_q     <= pc;
            link_val <= pc + PC_W'(4);
            rd_addr  <= rd_select(IR);
            link_we  <= (decode(IR) == K_BL);
            busy     <= 1'b1;
            state    <= S_EX0;
          end
        end
        S_EX0: begin
          pc_out  <= taken ? target : seq_pc;
          illegal <= (kind == K_ILL);
          done    <= 1'b1;
          pc_load <= 1'b1;
          state   <= S_EX1;
        end
        S_EX1: begin
          busy    <= 1'b0;
          rd_addr <= '0;
          illegal <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] taken_q;
  logic [CNT_W-1:0] nt_q;

  // Not-taken branches are necessarily conditional, since B/BL/BR always take.
  always_ff @(posedge clock) begin
    if (reset) begin
      taken_q <= '0;
      nt_q    <= '0;
    end else if (state == S_EX0 && kind != K_ILL) begin
      if (taken) begin
        if (taken_q != '1) taken_q <= taken_q + CNT_W'(1);
      end else begin
        if (nt_q != '1) nt_q <= nt_q + CNT_W'(1);
      end
    end
  end

  assign taken_cnt = taken_q;
  assign nt_cnt    = nt_q;
`else
  assign taken_cnt = '0;
  assign nt_cnt    = '0;
`endif

endmodule
